// File: rtl/seg_shift_ctrl.sv
// Serial 7-segment chain sequencer: encodes a 32-bit hex value into a 64-bit frame and shifts it out.
// Build option SEG_LZB_EN: leading-zero blanking of the upper digits.
module seg_shift_ctrl #(
  parameter int unsigned CLK_DIV        = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        upd_valid,
  input  logic [31:0] upd_data,
  input  logic [7:0]  upd_dp,
  output logic        upd_ready,
  output logic        done,
  output logic        SEGCLK,
  output logic        SEGCLR,
  output logic        SEGDT,
  output logic        SEGEN
);

  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] LOW_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] PER_LAST = DIV_W'(2 * CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [63:0] enc_frame;

  // Digit 7 lands in the top byte so it is shifted out first
  always_comb begin : encode
    logic [7:0] blank;
    logic [7:0] seg_byte;
    enc_frame = '0;
    blank     = '0;
    seg_byte  = '0;
`ifdef SEG_LZB_EN
    blank[7] = (upd_data[31:28] == 4'd0);
    for (int i = 6; i >= 1; i--) begin
      blank[i] = blank[i+1] && (upd_data[4*i +: 4] == 4'd0);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      seg_byte = {upd_dp[i], blank[i] ? 7'd0 : hex_to_seg(upd_data[4*i +: 4])};
      if (SEG_ACTIVE_LOW) seg_byte = ~seg_byte;
      enc_frame[8*i +: 8] = seg_byte;
    end
  end

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic [63:0]      frame_q, frame_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             segclk_q, segclk_d;
  logic             segclr_q, segclr_d;
  logic             segdt_q, segdt_d;
  logic             segen_q, segen_d;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    segclk_d = segclk_q;
    segclr_d = segclr_q;
    segdt_d  = segdt_q;
    segen_d  = segen_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (upd_valid && ready_q) begin
          frame_d  = enc_frame;
          state_d  = ST_CLEAR;
          ready_d  = 1'b0;
          segclr_d = 1'b0;
          div_d    = '0;
          bit_d    = '0;
        end
      end
      ST_CLEAR: begin
        if (div_q == PER_LAST) begin
          div_d    = '0;
          segclr_d = 1'b1;
          segdt_d  = frame_q[63];
          state_d  = ST_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // Low phase then high phase; next bit is presented as SEGCLK falls
        if (div_q == LOW_LAST) begin
          segclk_d = 1'b1;
          div_d    = div_q + 1'b1;
        end else if (div_q == PER_LAST) begin
          segclk_d = 1'b0;
          div_d    = '0;
          if (bit_q == 6'd63) begin
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            frame_d = {frame_q[62:0], 1'b0};
            segdt_d = frame_q[62];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        segen_d = 1'b1;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      segclk_q <= 1'b0;
      segclr_q <= 1'b1;
      segdt_q  <= 1'b0;
      segen_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      segclk_q <= segclk_d;
      segclr_q <= segclr_d;
      segdt_q  <= segdt_d;
      segen_q  <= segen_d;
    end
  end

  assign upd_ready = ready_q;
  assign done      = done_q;
  assign SEGCLK    = segclk_q;
  assign SEGCLR    = segclr_q;
  assign SEGDT     = segdt_q;
  assign SEGEN     = segen_q;

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Self-checking bench for seg_shift_ctrl: captures the shifted frame and timing from the chain pins.
// Expected frames follow SEG_LZB_EN when it is defined for the build.
module tb_seg_shift_ctrl;

  localparam int unsigned DIV   = 1;
  localparam int          LAT   = 130 * DIV + 1;
  localparam int          LIMIT = LAT + 40;

  logic        sysclk;
  logic        rst;
  logic        upd_valid;
  logic [31:0] upd_data;
  logic [7:0]  upd_dp;
  logic        upd_ready;
  logic        done;
  logic        SEGCLK;
  logic        SEGCLR;
  logic        SEGDT;
  logic        SEGEN;

  int checks   = 0;
  int failures = 0;

  seg_shift_ctrl #(.CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .upd_valid(upd_valid),
    .upd_data (upd_data),
    .upd_dp   (upd_dp),
    .upd_ready(upd_ready),
    .done     (done),
    .SEGCLK   (SEGCLK),
    .SEGCLR   (SEGCLR),
    .SEGDT    (SEGDT),
    .SEGEN    (SEGEN)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  dp;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {SEGCLK,SEGCLR,SEGDT,SEGEN,upd_ready,done}
  function automatic logic [63:0] pin_vec();
    return 64'({SEGCLK, SEGCLR, SEGDT, SEGEN, upd_ready, done});
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the done pulse
  task automatic run_frame(input logic [31:0] d, input logic [7:0] dp, input logic [63:0] exp,
                           input bit segen_pre, input int pulse_k, input bit hold,
                           input logic [31:0] d2, input logic [7:0] dp2, input string name);
    logic [63:0] got;
    int clr_low, rises, done_k;
    bit prev_clk, segen_bad;
    got = '0; clr_low = 0; rises = 0; done_k = -1; prev_clk = 1'b0; segen_bad = 1'b0;
    upd_valid = 1'b1;
    upd_data  = d;
    upd_dp    = dp;
    chk($sformatf("%s_ready_pre", name), 64'(upd_ready), 64'd1);
    @(posedge sysclk);
    for (int k = 0; k < LIMIT && done_k < 0; k++) begin
      @(negedge sysclk);
      if (k == 0) chk($sformatf("%s_ready_drop", name), 64'(upd_ready), 64'd0);
      if (k == pulse_k) chk($sformatf("%s_busy_ready", name), 64'(upd_ready), 64'd0);
      if (hold || k == pulse_k) begin
        upd_valid = 1'b1;
        upd_data  = d2;
        upd_dp    = dp2;
      end else begin
        upd_valid = 1'b0;
        upd_data  = d2;
      end
      if (!SEGCLR) clr_low++;
      if (SEGCLK && !prev_clk) begin
        got = {got[62:0], SEGDT};
        rises++;
      end
      prev_clk = SEGCLK;
      if (done) done_k = k;
      else if (SEGEN !== segen_pre) segen_bad = 1'b1;
    end
    chk($sformatf("%s_latency", name), 64'(done_k), 64'(LAT));
    chk($sformatf("%s_clr_low", name), 64'(clr_low), 64'(2 * DIV));
    chk($sformatf("%s_rises", name), 64'(rises), 64'd64);
    chk($sformatf("%s_frame", name), got, exp);
    chk($sformatf("%s_segen_before", name), 64'(segen_bad), 64'd0);
    chk($sformatf("%s_segen_at_done", name), 64'(SEGEN), 64'd1);
    chk($sformatf("%s_ready_at_done", name), 64'(upd_ready), 64'd1);
    if (!hold) begin
      @(negedge sysclk);
      chk($sformatf("%s_idle_pins", name), pin_vec(), 64'b010110 | 64'(SEGDT) << 3);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 8'h00, 64'hC0C0C0C0C0C0C0C0};
    vecs[1] = '{32'h0123_ABCD, 8'h01, 64'hC0F9A4B08883C621};
    vecs[2] = '{32'h0000_0A05, 8'h00, 64'hC0C0C0C0C088C092};
    vecs[3] = '{32'hFFFF_FFFF, 8'hFF, 64'h0E0E0E0E0E0E0E0E};
    vecs[4] = '{32'h89AB_CDEF, 8'hA0, 64'h00900883C6A1868E};
    vecs[5] = '{32'h1000_0000, 8'h02, 64'hF9C0C0C0C0C040C0};
    vecs[6] = '{32'h0000_0005, 8'h80, 64'h40C0C0C0C0C0C092};
`ifdef SEG_LZB_EN
    vecs[0].exp = 64'hFFFFFFFFFFFFFFC0;
    vecs[1].exp = 64'hFFF9A4B08883C621;
    vecs[2].exp = 64'hFFFFFFFFFF88C092;
    vecs[6].exp = 64'h7FFFFFFFFFFFFF92;
`endif

    rst = 1'b1; upd_valid = 1'b0; upd_data = '0; upd_dp = '0;
    repeat (3) @(negedge sysclk);
    chk("reset_hold", pin_vec(), 64'b010010);
    rst = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("reset_release", pin_vec(), 64'b010010);
    rst = 1'b1;
    #1;
    chk("reset_mid_idle", pin_vec(), 64'b010010);
    @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].d, vecs[i].dp, vecs[i].exp, (i != 0), -1, 1'b0,
                ~vecs[i].d, ~vecs[i].dp, $sformatf("vec%0d", i));
    end

    // Request pulsed mid-shift must be dropped and must not disturb the frame
    run_frame(vecs[1].d, vecs[1].dp, vecs[1].exp, 1'b1, 50, 1'b0,
              vecs[4].d, vecs[4].dp, "pulse_busy");
    @(negedge sysclk);
    chk("pulse_not_queued", 64'({upd_ready, SEGCLR}), 64'b11);

    // Held request with changing data: first frame unaffected, second accepted on first idle cycle
    run_frame(vecs[2].d, vecs[2].dp, vecs[2].exp, 1'b1, -1, 1'b1,
              vecs[4].d, vecs[4].dp, "hold_first");
    run_frame(vecs[4].d, vecs[4].dp, vecs[4].exp, 1'b1, -1, 1'b0,
              vecs[4].d, vecs[4].dp, "hold_second");

    // Reset in the middle of a frame
    begin
      int rises;
      bit prev;
      rises = 0; prev = 1'b0;
      upd_valid = 1'b1; upd_data = vecs[3].d; upd_dp = vecs[3].dp;
      @(posedge sysclk);
      for (int k = 0; k < LIMIT && rises < 30; k++) begin
        @(negedge sysclk);
        upd_valid = 1'b0;
        if (SEGCLK && !prev) rises++;
        prev = SEGCLK;
      end
      chk("midframe_reach_bit30", 64'(rises), 64'd30);
      rst = 1'b1;
      #1;
      chk("reset_midframe", pin_vec(), 64'b010010);
      @(negedge sysclk);
      rst = 1'b0;
      @(negedge sysclk);
      chk("reset_midframe_release", pin_vec(), 64'b010010);
    end
    run_frame(vecs[5].d, vecs[5].dp, vecs[5].exp, 1'b0, -1, 1'b0,
              vecs[0].d, vecs[0].dp, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
